ni_packetizer: RTL and testbench
================================

# ni_packetizer

Downstream stage of the network interface: pops {address, data} write entries from the NI write FIFO and serializes each into a three-flit packet (head, body, tail) toward the local router input port. It owns the FIFO read side and a valid/ready handshake to the router, and it stamps each packet with source coordinates and a sequence number. One packet is in flight at a time. The packetizer is the only reader of the write FIFO.

## Interface
Parameters:
- LOCAL_X, 0: 4-bit mesh X coordinate of this node
- LOCAL_Y, 0: 4-bit mesh Y coordinate of this node

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- fifo_empty  in  1  write FIFO empty flag
- fifo_rd_en  out  1  FIFO pop request, one-cycle pulse
- fifo_rd_data  in  64  {addr[31:0], data[31:0]}; valid the cycle after fifo_rd_en
- flit_out  out  34  {type[1:0], payload[31:0]}
- flit_valid  out  1  flit_out holds a valid flit
- flit_ready  in  1  router accepts flit_out this cycle
- busy  out  1  high in any state other than IDLE
- pkt_count  out  16  packets fully sent since reset (wraps)

## Operation
- Flit types: 2'b00 none, 2'b01 head, 2'b10 body, 2'b11 tail.
- Head payload: [31:28] dst_x = addr[31:28], [27:24] dst_y = addr[27:24], [23:20] LOCAL_X, [19:16] LOCAL_Y, [15:0] pkt_count at packet start.
- Body payload is addr[31:0]. Tail payload is data[31:0].
- FSM states: IDLE, FETCH, HEAD, BODY, TAIL.
  - IDLE: fifo_rd_en = !fifo_empty (combinational). Go to FETCH when it is 1.
  - FETCH: capture fifo_rd_data into the addr/data registers. Go to HEAD.
  - HEAD, BODY, TAIL: flit_valid = 1 and flit_out = the corresponding flit. Advance only on flit_valid && flit_ready.
  - TAIL handshake: pkt_count increments and the FSM goes to IDLE.
- fifo_rd_en is 0 in every state except IDLE, so there is never more than one outstanding pop.
- While flit_valid = 1 and flit_ready = 0, flit_out and flit_valid must hold stable.
- When flit_valid = 0, flit_out is 34'h0.
- Address bits [23:0] travel only in the body flit; no other routing decode happens here.

## Timing
- Reset values: FSM = IDLE, fifo_rd_en = 0, flit_valid = 0, flit_out = 0, busy = 0, pkt_count = 0, captured addr/data = 0.
- FSM state, captured payload and pkt_count are registers. flit_valid, flit_out and busy are decoded from the registered state (Moore outputs). fifo_rd_en is the only combinational output.
- Latency: fifo_rd_en in cycle N gives the head flit valid in cycle N+2. With flit_ready held at 1, body is valid in N+3 and tail in N+4. pkt_count updates at the end of N+4 and is visible in N+5.
- Back-to-back traffic: IDLE re-evaluates fifo_empty in N+5. Peak throughput is 1 packet per 5 cycles.
- Router backpressure stalls the FSM indefinitely with no loss or reordering.
- fifo_empty asserting after the pop has no effect on the packet in flight.
- pkt_count wraps from 16'hFFFF to 16'h0000.
- Reset asserted mid-packet: all outputs return to their reset values immediately (asynchronous). The popped entry is discarded, and after release the FSM starts from IDLE.
- flit_ready while flit_valid = 0 is ignored.

## Test plan
- Single packet: with LOCAL_X = 1 and LOCAL_Y = 2, push addr 32'hA5A5A5A5 / data 32'hAAAAAAAA with flit_ready = 1. Required flits: 34'h1_A5120000, then 34'h2_A5A5A5A5, then 34'h3_AAAAAAAA, in three consecutive cycles starting 2 cycles after fifo_rd_en. pkt_count becomes 1.
- Backpressure: hold flit_ready = 0 for 4 cycles during the body flit. flit_out must stay 34'h2_A5A5A5A5 with flit_valid = 1, and the tail follows the cycle after flit_ready rises.
- Back-to-back: 3 entries queued with flit_ready = 1. Required: 9 flits, fifo_rd_en pulses exactly 5 cycles apart, head sequence fields 0, 1, 2, and final pkt_count = 3.
- Empty FIFO: fifo_empty = 1 for 20 cycles. Required: fifo_rd_en = 0, flit_valid = 0, busy = 0 throughout.
- Reset mid-packet: drive reset low during the BODY state. Required: flit_valid = 0 and pkt_count = 0 before the next clock edge. After release, a new entry yields a head flit with sequence 0.
- Wrap: preload pkt_count to 16'hFFFF by sending 65535 packets (fast mode allowed), then send one more. Required: that packet's head carries sequence 16'hFFFF, and pkt_count reads 16'h0000 afterwards.

Source files
------------

// File: rtl/ni_packetizer.sv
// ni_packetizer: serializes popped {addr, data} FIFO entries into head/body/tail flits for the local router port.
module ni_packetizer #(
    parameter logic [3:0] LOCAL_X = 4'd0,
    parameter logic [3:0] LOCAL_Y = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [63:0] fifo_rd_data,
    output logic [33:0] flit_out,
    output logic        flit_valid,
    input  logic        flit_ready,
    output logic        busy,
    output logic [15:0] pkt_count
);
    typedef enum logic [2:0] {IDLE, FETCH, HEAD, BODY, TAIL} state_t;
    state_t      state;
    logic [31:0] addr;
    logic [31:0] data;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= '0;
            data      <= '0;
            pkt_count <= '0;
        end else begin
            case (state)
                IDLE:    if (!fifo_empty) state <= FETCH;
                FETCH: begin
                    addr  <= fifo_rd_data[63:32];
                    data  <= fifo_rd_data[31:0];
                    state <= HEAD;
                end
                HEAD:    if (flit_ready) state <= BODY;
                BODY:    if (flit_ready) state <= TAIL;
                TAIL: if (flit_ready) begin
                    state     <= IDLE;
                    pkt_count <= pkt_count + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // pkt_count only moves on the tail handshake, so it still holds this packet's sequence number
    always_comb begin
        fifo_rd_en = (state == IDLE) && !fifo_empty;
        busy       = state != IDLE;
        flit_valid = (state == HEAD) || (state == BODY) || (state == TAIL);
        flit_out   = (state == HEAD) ? {2'b01, addr[31:24], LOCAL_X, LOCAL_Y, pkt_count} :
                     (state == BODY) ? {2'b10, addr} :
                     (state == TAIL) ? {2'b11, data} : 34'h0;
    end
endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: randomized and directed stimulus checked against a queue-based packet model.
module tb_ni_packetizer;
    logic        clk;
    logic        reset;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [63:0] fifo_rd_data;
    logic [33:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;
    logic        busy;
    logic [15:0] pkt_count;

    ni_packetizer #(.LOCAL_X(4'd1), .LOCAL_Y(4'd2)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .flit_out(flit_out), .flit_valid(flit_valid),
        .flit_ready(flit_ready), .busy(busy), .pkt_count(pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          age = 100;
    int          rdy_mode = 0;
    int          stall_left = 0;
    bit          inflight = 0;
    bit          fifo_pend = 0;
    bit          held = 0;
    logic [33:0] held_flit;
    logic [63:0] pend_d;
    logic [15:0] m_seq = 0;
    logic [15:0] m_cnt = 0;
    logic [63:0] fq[$];
    logic [33:0] exp_q[$];
    logic [33:0] seen[$];
    int          pops[$];

    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs on the falling edge, then check outputs and advance the model.
    task automatic step();
        logic [63:0] a;
        logic [33:0] e;
        bit          exp_rd;
        @(negedge clk);
        cyc++;
        fifo_rd_data = fifo_pend ? pend_d : {$urandom, $urandom};
        fifo_pend = 0;
        fifo_empty = (fq.size() == 0);
        flit_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (stall_left > 0 && flit_valid && flit_out[33:32] == 2'b10) begin
            flit_ready = 1'b0;
            stall_left--;
        end
        #1;
        age++;
        exp_rd = !inflight && !fifo_empty;
        chk("busy", 34'(busy), 34'(inflight));
        chk("rd_en", 34'(fifo_rd_en), 34'(exp_rd));
        chk("valid", 34'(flit_valid), 34'(inflight && age >= 2));
        chk("pkt_count", 34'(pkt_count), 34'(m_cnt));
        if (held) chk("hold", flit_out, held_flit);
        if (!flit_valid) chk("idle_zero", flit_out, 34'h0);
        held = flit_valid && !flit_ready;
        held_flit = flit_out;
        if (flit_valid && flit_ready) begin
            if (exp_q.size() == 0) chk("extra_flit", flit_out, 34'h0);
            else begin
                e = exp_q.pop_front();
                chk("flit", flit_out, e);
                seen.push_back(flit_out);
                if (e[33:32] == 2'b11) begin
                    inflight = 0;
                    m_cnt++;
                end
            end
        end
        if (exp_rd) begin
            a = fq.pop_front();
            pend_d = a;
            fifo_pend = 1;
            pops.push_back(cyc);
            exp_q.push_back({2'b01, a[63:56], 4'd1, 4'd2, m_seq});
            exp_q.push_back({2'b10, a[63:32]});
            exp_q.push_back({2'b11, a[31:0]});
            m_seq++;
            inflight = 1;
            age = 0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((inflight || fq.size() > 0) && n < 400) begin
            step();
            n++;
        end
        if (inflight || fq.size() > 0) chk("drain_timeout", 34'h1, 34'h0);
        step();
    endtask

    initial begin
        reset = 1'b0;
        fifo_empty = 1'b1;
        flit_ready = 1'b0;
        fifo_rd_data = '0;
        #12;
        chk("rst_valid", 34'(flit_valid), 34'h0);
        chk("rst_flit", flit_out, 34'h0);
        chk("rst_busy", 34'(busy), 34'h0);
        chk("rst_rd_en", 34'(fifo_rd_en), 34'h0);
        chk("rst_count", 34'(pkt_count), 34'h0);
        @(negedge clk);
        reset = 1'b1;

        // Empty FIFO: nothing may happen
        repeat (20) step();

        // Single packet
        seen.delete();
        fq.push_back({32'hA5A5A5A5, 32'hAAAAAAAA});
        drain();
        chk("single_head", seen[0], 34'h1_A5120000);
        chk("single_body", seen[1], 34'h2_A5A5A5A5);
        chk("single_tail", seen[2], 34'h3_AAAAAAAA);
        chk("single_cnt", 34'(pkt_count), 34'd1);

        // Backpressure on the body flit
        stall_left = 4;
        fq.push_back({32'hA5A5A5A5, 32'h12345678});
        drain();
        chk("stall_used", 34'(stall_left), 34'd0);

        // Back-to-back
        pops.delete();
        repeat (3) fq.push_back({$urandom, $urandom});
        drain();
        chk("b2b_gap1", 34'(pops[1] - pops[0]), 34'd5);
        chk("b2b_gap2", 34'(pops[2] - pops[1]), 34'd5);
        chk("b2b_cnt", 34'(pkt_count), 34'd5);

        // Random traffic and random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && fq.size() < 4) fq.push_back({$urandom, $urandom});
            step();
        end
        drain();
        rdy_mode = 0;

        // Reset in the body state
        fq.push_back({$urandom, $urandom});
        for (int n = 0; n < 20 && !(flit_valid && flit_out[33:32] == 2'b10); n++) step();
        chk("reached_body", flit_out[33:32], 2'b10);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 34'(flit_valid), 34'h0);
        chk("mid_rst_flit", flit_out, 34'h0);
        chk("mid_rst_count", 34'(pkt_count), 34'h0);
        chk("mid_rst_busy", 34'(busy), 34'h0);
        exp_q.delete();
        fq.delete();
        inflight = 0;
        fifo_pend = 0;
        held = 0;
        m_seq = 0;
        m_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        seen.delete();
        fq.push_back({$urandom, $urandom});
        drain();
        chk("post_rst_seq", 34'(seen[0][15:0]), 34'h0);

        // Wrap: preload the counter, then one more packet
        force dut.pkt_count = 16'hFFFF;
        #1 release dut.pkt_count;
        m_seq = 16'hFFFF;
        m_cnt = 16'hFFFF;
        seen.delete();
        fq.push_back({$urandom, $urandom});
        drain();
        chk("wrap_seq", 34'(seen[0][15:0]), 34'hFFFF);
        chk("wrap_cnt", 34'(pkt_count), 34'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
